// File: rtl/prime_range_scanner_if.sv
// Bundle of the host-side start/range/status signals and the checker handshake for the
// prime range scanner. The scanner connects through the slave modport; the host/checker
// side (or a testbench) connects through the master modport.
interface prime_range_scanner_if #(
  parameter int unsigned NO_W  = 10,
  parameter int unsigned CNT_W = 8
);
  logic             start;
  logic [NO_W-1:0]  range_lo;
  logic [NO_W-1:0]  range_hi;
  logic [NO_W-1:0]  cand_no;
  logic             cand_valid;
  logic             res_ready;
  logic             res_is_prime;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] prime_count;
  logic [NO_W-1:0]  last_prime;
  logic             timeout_err;

  modport slave (
    input  start, range_lo, range_hi, res_ready, res_is_prime,
    output cand_no, cand_valid, busy, done, prime_count, last_prime, timeout_err
  );

  modport master (
    output start, range_lo, range_hi, res_ready, res_is_prime,
    input  cand_no, cand_valid, busy, done, prime_count, last_prime, timeout_err
  );
endinterface

// File: rtl/prime_range_scanner.sv
// Prime range scanner: walks every integer in [range_lo, range_hi], hands each one to the
// prime checker with a one-cycle valid pulse, waits for the result pulse and accumulates the
// prime count and the largest prime seen. All outputs are registered.
// Optional feature: define PRIME_SCAN_WATCHDOG_EN to abort a scan (sticky timeout_err) when
// the checker fails to answer within TIMEOUT cycles of WAIT.
module prime_range_scanner #(
  parameter int unsigned NO_W    = 10,
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic                  clock,
  input  logic                  reset,
  prime_range_scanner_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

  // The watchdog compares against TIMEOUT-1, so zero is meaningless.
  if (TIMEOUT == 0) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

  state_e           state_q, state_d;
  // One bit wider than a candidate so range_hi = 2^NO_W-1 never wraps.
  logic [NO_W:0]    cur_q, cur_d;
  logic [NO_W-1:0]  hi_q, hi_d;
  logic [NO_W-1:0]  cand_no_q, cand_no_d;
  logic             cand_valid_q, cand_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NO_W-1:0]  last_q, last_d;

`ifdef PRIME_SCAN_WATCHDOG_EN
  localparam int unsigned WdW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  logic [WdW-1:0] wd_q, wd_d;
  logic           terr_q, terr_d;
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    hi_d      = hi_q;
    cand_no_d = cand_no_q;
    cnt_d     = cnt_q;
    last_d    = last_q;
`ifdef PRIME_SCAN_WATCHDOG_EN
    wd_d      = wd_q;
    terr_d    = terr_q;
`endif

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          hi_d   = bus.range_hi;
          cnt_d  = '0;
          last_d = '0;
`ifdef PRIME_SCAN_WATCHDOG_EN
          terr_d = 1'b0;
`endif
          if (bus.range_lo > bus.range_hi) begin
            state_d = StDone;
          end else begin
            cur_d     = {1'b0, bus.range_lo};
            cand_no_d = bus.range_lo;
            state_d   = StIssue;
          end
        end
      end

      StIssue: begin
`ifdef PRIME_SCAN_WATCHDOG_EN
        wd_d = '0;
`endif
        state_d = StWait;
      end

      StWait: begin
        if (bus.res_ready) begin
          if (bus.res_is_prime) begin
            if (cnt_q != {CNT_W{1'b1}}) begin
              cnt_d = cnt_q + 1'b1;
            end
            last_d = cur_q[NO_W-1:0];
          end
          if (cur_q == {1'b0, hi_q}) begin
            state_d = StDone;
          end else begin
            cur_d     = cur_q + 1'b1;
            cand_no_d = cur_d[NO_W-1:0];
            state_d   = StIssue;
          end
        end
`ifdef PRIME_SCAN_WATCHDOG_EN
        // wd_q counts completed WAIT cycles; abort after TIMEOUT of them.
        else if (wd_q == WdW'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = StDone;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    cand_valid_d = (state_d == StIssue);
    busy_d       = (state_d == StIssue) || (state_d == StWait);
    done_d       = (state_d == StDone);
  end

  // State and output registers; reset discards any partial scan.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cur_q        <= '0;
      hi_q         <= '0;
      cand_no_q    <= '0;
      cand_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      last_q       <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      hi_q         <= hi_d;
      cand_no_q    <= cand_no_d;
      cand_valid_q <= cand_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
    end
  end

`ifdef PRIME_SCAN_WATCHDOG_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_q   <= '0;
      terr_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      terr_q <= terr_d;
    end
  end

  assign bus.timeout_err = terr_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.cand_no     = cand_no_q;
  assign bus.cand_valid  = cand_valid_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.prime_count = cnt_q;
  assign bus.last_prime  = last_q;

endmodule
